// File: rtl/spi_target_pkg.sv
// rtl/spi_target_pkg.sv - shared types and constants for the SPI target
// Contents: default widths, FSM state encoding, command bit values.
package spi_target_pkg;

  localparam int SPIT_DATA_W = 8;
  localparam int SPIT_ADDR_W = 4;

  typedef enum logic [2:0] {
    SPIT_IDLE,
    SPIT_CMD,
    SPIT_ADDR,
    SPIT_DATA,
    SPIT_DONE
  } spit_state_t;

  localparam logic SPI_CMD_RD = 1'b0;
  localparam logic SPI_CMD_WR = 1'b1;

endpackage

// File: rtl/spi_target_if.sv
// rtl/spi_target_if.sv - SPI pins and local storage port of the SPI target
// slave modport  : the target (samples SPI pins, drives MISO and the local port)
// master modport : the link master plus the local storage responder
interface spi_target_if
  import spi_target_pkg::*;
#(
  parameter int DATA_W = SPIT_DATA_W,
  parameter int ADDR_W = SPIT_ADDR_W
);

  logic              sclk_in;
  logic              cs_n_in;
  logic              mosi_in;
  logic              miso_out;
  logic              miso_oe_out;
  logic              wr_strobe_out;
  logic [ADDR_W-1:0] wr_addr_out;
  logic [DATA_W-1:0] wr_data_out;
  logic              rd_req_out;
  logic [ADDR_W-1:0] rd_addr_out;
  logic [DATA_W-1:0] rd_data_in;
  logic              busy_out;
  logic              frame_err_out;

  modport slave (
    input  sclk_in, cs_n_in, mosi_in, rd_data_in,
    output miso_out, miso_oe_out, wr_strobe_out, wr_addr_out, wr_data_out,
           rd_req_out, rd_addr_out, busy_out, frame_err_out
  );

  modport master (
    output sclk_in, cs_n_in, mosi_in, rd_data_in,
    input  miso_out, miso_oe_out, wr_strobe_out, wr_addr_out, wr_data_out,
           rd_req_out, rd_addr_out, busy_out, frame_err_out
  );

endinterface

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - 2-flop pin synchroniser with optional edge detection
// Ports: clk, rst (async, active-high), i_pin (asynchronous pin),
//        o_sig: EDGES=0 -> [0] synchronised level
//               EDGES=1 -> [0] rise pulse, [1] fall pulse (one clk each)
module spi_sync #(
  parameter bit EDGES   = 1'b0,
  parameter bit RST_VAL = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_pin,
  output logic [(EDGES ? 2 : 1)-1:0] o_sig
);

  logic [1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {2{RST_VAL}};
    end else begin
      r_sync <= {r_sync[0], i_pin};
    end
  end

  if (EDGES) begin : g_edge
    logic r_prev;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_prev <= RST_VAL;
      end else begin
        r_prev <= r_sync[1];
      end
    end

    assign o_sig = {~r_sync[1] & r_prev, r_sync[1] & ~r_prev};
  end else begin : g_level
    assign o_sig = r_sync[1];
  end

endmodule

// File: rtl/spi_target.sv
// rtl/spi_target.sv - SPI mode-0 target bridging frames to a local storage port
// Ports: clk, rst (async, active-high), bus (spi_target_if.slave):
//   SPI pins sclk_in/cs_n_in/mosi_in in, miso_out/miso_oe_out out;
//   write strobe with addr/data, read request with addr, read data in;
//   busy_out (frame in progress), frame_err_out (cs_n rose mid-frame).
// Frame: cmd bit, ADDR_W address bits, DATA_W data bits, all MSB-first.
module spi_target
  import spi_target_pkg::*;
#(
  parameter int DATA_W = SPIT_DATA_W,
  parameter int ADDR_W = SPIT_ADDR_W
) (
  input  logic         clk,
  input  logic         rst,
  spi_target_if.slave  bus
);

  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);

  // r_cnt holds the number of bits already captured in this frame.
  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] DATA_FIRST = CNT_W'(ADDR_W + 1);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(FRAME_W - 1);

  logic [1:0] w_sclk_edge;
  logic       w_sclk_rise;
  logic       w_sclk_fall;
  logic       w_cs_n;
  logic       w_mosi;

  spi_sync #(.EDGES(1'b1), .RST_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .rst   (rst),
    .i_pin (bus.sclk_in),
    .o_sig (w_sclk_edge)
  );

  // cs_n resets to its idle (deasserted) level so reset release never
  // looks like a frame start or an abort.
  spi_sync #(.EDGES(1'b0), .RST_VAL(1'b1)) u_sync_cs_n (
    .clk   (clk),
    .rst   (rst),
    .i_pin (bus.cs_n_in),
    .o_sig (w_cs_n)
  );

  spi_sync #(.EDGES(1'b0), .RST_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst   (rst),
    .i_pin (bus.mosi_in),
    .o_sig (w_mosi)
  );

  assign w_sclk_rise = w_sclk_edge[0];
  assign w_sclk_fall = w_sclk_edge[1];

  spit_state_t       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_cmd;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_tx;
  logic              r_oe;
  logic              r_wr_pend;
  logic              r_wr_strobe;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_rd_req;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_frame_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= SPIT_IDLE;
      r_cnt       <= '0;
      r_cmd       <= 1'b0;
      r_addr      <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_oe        <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_rd_req    <= 1'b0;
      r_rd_addr   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_strobe <= 1'b0;
      r_rd_req    <= 1'b0;
      r_frame_err <= 1'b0;

      // Write commit happens one clk after the last data bit lands.
      if (r_wr_pend) begin
        r_wr_strobe <= 1'b1;
        r_wr_addr   <= r_addr;
        r_wr_data   <= r_rx;
        r_wr_pend   <= 1'b0;
      end

      if (w_cs_n && (r_state == SPIT_CMD || r_state == SPIT_ADDR ||
                     r_state == SPIT_DATA)) begin
        r_state     <= SPIT_IDLE;
        r_frame_err <= 1'b1;
        r_oe        <= 1'b0;
        r_tx        <= '0;
      end else begin
        case (r_state)
          SPIT_IDLE: begin
            if (!w_cs_n) begin
              r_state <= SPIT_CMD;
              r_cnt   <= '0;
            end
          end

          SPIT_CMD: begin
            if (w_sclk_rise) begin
              r_cmd   <= w_mosi;
              r_cnt   <= r_cnt + 1'b1;
              r_state <= SPIT_ADDR;
            end
          end

          SPIT_ADDR: begin
            if (w_sclk_rise) begin
              r_addr <= {r_addr[ADDR_W-2:0], w_mosi};
              r_cnt  <= r_cnt + 1'b1;
              if (r_cnt == ADDR_LAST) begin
                r_state <= SPIT_DATA;
                if (r_cmd == SPI_CMD_RD) begin
                  r_rd_req  <= 1'b1;
                  r_rd_addr <= {r_addr[ADDR_W-2:0], w_mosi};
                end
              end
            end
          end

          SPIT_DATA: begin
            if (r_rd_req) begin
              r_tx <= bus.rd_data_in;
              r_oe <= 1'b1;
            end else if (w_sclk_fall && r_cmd == SPI_CMD_RD &&
                         r_cnt != DATA_FIRST) begin
              // The fall between the last address rise and the first data
              // rise must keep the freshly loaded MSB on the line.
              r_tx <= {r_tx[DATA_W-2:0], 1'b0};
            end

            if (w_sclk_rise) begin
              r_cnt <= r_cnt + 1'b1;
              if (r_cmd == SPI_CMD_WR) begin
                r_rx <= {r_rx[DATA_W-2:0], w_mosi};
              end
              if (r_cnt == DATA_LAST) begin
                r_state <= SPIT_DONE;
                r_oe    <= 1'b0;
                r_tx    <= '0;
                if (r_cmd == SPI_CMD_WR) begin
                  r_wr_pend <= 1'b1;
                end
              end
            end
          end

          SPIT_DONE: begin
            if (w_cs_n) begin
              r_state <= SPIT_IDLE;
            end
          end

          default: r_state <= SPIT_IDLE;
        endcase
      end
    end
  end

  assign bus.miso_out      = r_oe & r_tx[DATA_W-1];
  assign bus.miso_oe_out   = r_oe;
  assign bus.wr_strobe_out = r_wr_strobe;
  assign bus.wr_addr_out   = r_wr_addr;
  assign bus.wr_data_out   = r_wr_data;
  assign bus.rd_req_out    = r_rd_req;
  assign bus.rd_addr_out   = r_rd_addr;
  assign bus.busy_out      = (r_state != SPIT_IDLE);
  assign bus.frame_err_out = r_frame_err;

endmodule

// File: tb/tb_spi_target.sv
// tb/tb_spi_target.sv - self-checking bench for spi_target
module tb_spi_target;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  spi_target_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  spi_target #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;

  int         n_wr = 0;
  int         n_rd = 0;
  int         n_fe = 0;
  logic [3:0] last_wa = '0;
  logic [7:0] last_wd = '0;
  logic [3:0] last_ra = '0;
  logic       oe_seen = 1'b0;
  logic [7:0] mem [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Local storage responder and pulse monitor.
  always @(negedge clk) begin
    if (bus.rd_req_out) bus.rd_data_in = mem[bus.rd_addr_out];
    else                bus.rd_data_in = 8'($urandom);
    if (!rst) begin
      int pulses;
      pulses = int'(bus.wr_strobe_out) + int'(bus.rd_req_out) + int'(bus.frame_err_out);
      if (pulses > 0) chk("pulse_excl", pulses, 1);
      if (bus.wr_strobe_out) begin
        n_wr++;
        last_wa = bus.wr_addr_out;
        last_wd = bus.wr_data_out;
      end
      if (bus.rd_req_out) begin
        n_rd++;
        last_ra = bus.rd_addr_out;
      end
      if (bus.frame_err_out) n_fe++;
      if (bus.miso_oe_out) oe_seen = 1'b1;
      else                 chk("miso_idle", bus.miso_out, 0);
    end
  end

  task automatic sclk_bit(input logic b, output logic m);
    bus.mosi_in = b;
    repeat (5) @(negedge clk);
    m = bus.miso_out;
    bus.sclk_in = 1'b1;
    repeat (5) @(negedge clk);
    bus.sclk_in = 1'b0;
  endtask

  task automatic run_frame(input logic cmd, input logic [3:0] addr, input logic [7:0] data,
                           input int nbits, input int gap);
    logic [12:0] fr;
    logic [7:0]  rx;
    logic [7:0]  exp_rd;
    logic        m;
    int          wr0, rd0, fe0;
    fr = {cmd, addr, data};
    wr0 = n_wr; rd0 = n_rd; fe0 = n_fe;
    exp_rd = mem[addr];
    rx = '0;
    oe_seen = 1'b0;
    bus.cs_n_in = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      sclk_bit((i < 13) ? fr[12-i] : 1'($urandom), m);
      if (i >= 5 && i < 13) rx[12-i] = m;
    end
    repeat (5) @(negedge clk);
    chk("busy_end", bus.busy_out, 1);
    bus.cs_n_in = 1'b1;
    repeat (gap) @(negedge clk);
    #1;
    if (nbits >= 13) begin
      chk("fe_cnt", n_fe - fe0, 0);
      if (cmd) begin
        chk("wr_cnt", n_wr - wr0, 1);
        chk("wr_addr", last_wa, addr);
        chk("wr_data", last_wd, data);
        chk("rd_cnt_wr", n_rd - rd0, 0);
        chk("oe_wr", oe_seen, 0);
        mem[addr] = data;
      end else begin
        chk("rd_cnt", n_rd - rd0, 1);
        chk("rd_addr", last_ra, addr);
        chk("miso_data", rx, exp_rd);
        chk("wr_cnt_rd", n_wr - wr0, 0);
        chk("oe_rd", oe_seen, 1);
      end
    end else begin
      chk("abort_fe", n_fe - fe0, 1);
      chk("abort_wr", n_wr - wr0, 0);
      chk("abort_rd", n_rd - rd0, (!cmd && nbits >= 5) ? 1 : 0);
    end
    chk("busy_after", bus.busy_out, 0);
    chk("oe_after", bus.miso_oe_out, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, bus.busy_out, 0);
    chk({tag, "_oe"}, bus.miso_oe_out, 0);
    chk({tag, "_miso"}, bus.miso_out, 0);
    chk({tag, "_wr"}, bus.wr_strobe_out, 0);
    chk({tag, "_rd"}, bus.rd_req_out, 0);
    chk({tag, "_fe"}, bus.frame_err_out, 0);
    chk({tag, "_waddr"}, bus.wr_addr_out, 0);
    chk({tag, "_wdata"}, bus.wr_data_out, 0);
    chk({tag, "_raddr"}, bus.rd_addr_out, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] fr;
    logic        m;
    int          fe0, wr0;

    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    bus.sclk_in = 1'b0;
    bus.cs_n_in = 1'b1;
    bus.mosi_in = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    run_frame(1'b1, 4'h5, 8'hA3, 13, 4);
    mem[4'hC] = 8'h5A;
    run_frame(1'b0, 4'hC, 8'h00, 13, 4);
    run_frame(1'b1, 4'h9, 8'h55, 6, 4);
    run_frame(1'b1, 4'h1, 8'hFF, 13, 4);
    run_frame(1'b1, 4'h2, 8'h3C, 29, 4);

    // Reset mid-DATA of a read.
    fe0 = n_fe;
    wr0 = n_wr;
    fr = {1'b0, 4'h6, 8'h00};
    bus.cs_n_in = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 9; i++) sclk_bit(fr[12-i], m);
    chk("pre_rst_oe", bus.miso_oe_out, 1);
    rst = 1'b1;
    #1;
    chk_all_zero("mid_rst");
    bus.cs_n_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_no_fe", n_fe - fe0, 0);
    chk("rst_no_wr", n_wr - wr0, 0);
    run_frame(1'b1, 4'hF, 8'h01, 13, 4);

    // Back-to-back with minimum cs_n gap.
    run_frame(1'b1, 4'h3, 8'h77, 13, 3);
    run_frame(1'b0, 4'h3, 8'h00, 13, 4);
    chk("b2b_mem", mem[3], 8'h77);

    for (int k = 0; k < 20; k++) begin
      logic       c;
      logic [3:0] a;
      logic [7:0] d;
      int         r, nb;
      c  = 1'($urandom);
      a  = 4'($urandom);
      d  = 8'($urandom);
      r  = $urandom_range(0, 4);
      nb = (r == 0) ? $urandom_range(1, 12) : 13 + $urandom_range(0, 3);
      run_frame(c, a, d, nb, $urandom_range(3, 6));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI mode-0 responder: the device-side end of the processor's SPI master link.
- Deserialises MSB-first frames of 1 command bit + ADDR_W address bits + DATA_W data bits.
- Writes go to a local storage/peripheral port as a one-cycle strobe; reads fetch a word from that port and shift it out on MISO.
- All pins are sampled in the local clk domain through synchronisers.

Parameters:
- DATA_W, `DATAPATH_W, data word width in bits.
- ADDR_W, `CLOG2(`DMEM_SZ), address width in bits.
- FRAME_W, 1+ADDR_W+DATA_W, total frame length (localparam, derived).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- sclk_in  in  1  SPI clock from master, idle low.
- cs_n_in  in  1  chip select, active low.
- mosi_in  in  1  serial data from master.
- miso_out  out  1  serial data to master.
- miso_oe_out  out  1  high while this target drives MISO.
- wr_strobe_out  out  1  one-cycle write pulse to local port.
- wr_addr_out  out  ADDR_W  write address, valid with the strobe.
- wr_data_out  out  DATA_W  write data, valid with the strobe.
- rd_req_out  out  1  one-cycle read request pulse.
- rd_addr_out  out  ADDR_W  read address, held from rd_req until frame end.
- rd_data_in  in  DATA_W  read data, sampled exactly 1 clk after rd_req_out.
- busy_out  out  1  high when a frame is in progress (state != IDLE).
- frame_err_out  out  1  one-cycle pulse when cs_n rises mid-frame.

Behaviour:
- Input conditioning
  - sclk_in, cs_n_in and mosi_in each pass a 2-flop synchroniser.
  - A third register on sclk yields single-cycle rise/fall pulses.
  - Source timing requirement: sclk high and low phases of at least 4 clk each.
- Reset
  - All outputs 0; state IDLE; shift registers and counters 0.
  - Asserting rst mid-frame aborts immediately with no strobe and no frame_err.
- SPI mode 0
  - MOSI is sampled on a rise pulse.
  - MISO changes on a fall pulse.
  - Bits are MSB-first.
- States: IDLE, CMD, ADDR, DATA, DONE.
  - IDLE: synchronised cs_n low -> CMD; bit counter cleared.
  - CMD: on rise, capture cmd bit (1 = write, 0 = read) -> ADDR.
  - ADDR: shift ADDR_W bits. On the rise that captures the last address bit, go to DATA. If cmd = 0, assert rd_req_out for 1 clk and drive rd_addr_out from the same cycle.
  - DATA, read: 1 clk after rd_req, load rd_data_in into the TX register. Set miso_oe_out = 1 and drive miso_out = TX MSB. Each subsequent fall shifts TX left by one. This places bit DATA_W-1 on MISO before the first data-phase rise.
  - DATA, write: shift DATA_W MOSI bits. On the rise capturing the last bit, go to DONE. The next clk pulses wr_strobe_out with wr_addr_out/wr_data_out held stable until the next strobe.
  - DATA, read completion: go to DONE after DATA_W rise pulses.
  - DONE: further sclk edges are ignored; miso_oe_out = 0, miso_out = 0; return to IDLE on cs_n high.
- cs_n high in CMD, ADDR or DATA
  - Return to IDLE, pulse frame_err_out for 1 clk, no wr_strobe.
  - miso_oe_out drops the same cycle.
  - A pending rd_req already issued is not retracted.
- Output defaults
  - miso_out = 0 whenever miso_oe_out = 0.
  - wr_strobe_out, rd_req_out and frame_err_out are never high simultaneously.
- Back-to-back frames
  - cs_n high for at least 3 clk is sufficient.
  - A new frame restarts from CMD with a cleared counter.
- Bit counter width: `CLOG2(FRAME_W+1); it never wraps within a frame.

Decomposition:
- defs.vh: state encodings (SPIT_IDLE..SPIT_DONE) and the command bit values SPI_CMD_RD = 0, SPI_CMD_WR = 1. `CLOG2 is reused.
- Sub-module spi_sync: 2-flop synchroniser plus edge register, parameterised for the level-only vs rise/fall outputs. Instantiate for sclk (edges), cs_n and mosi (level).
- The FSM, RX/TX shift registers and counter stay in spi_target.

Test Plan (DATA_W = 8, ADDR_W = 4, sclk period 10 clk):
- Write frame cmd = 1, addr = 0x5, data = 0xA3, cs_n high after -> exactly one wr_strobe_out with addr 0x5 and data 0xA3; rd_req_out never high; miso_oe_out stays 0.
- Read frame cmd = 0, addr = 0xC, rd_data_in = 0x5A -> one rd_req_out with rd_addr_out = 0xC; MISO sampled on the 8 data rises reads 0,1,0,1,1,0,1,0; miso_oe_out low after the frame.
- Abort: cs_n high after 6 bits of a write frame -> frame_err_out pulses once, no wr_strobe_out, busy_out falls; the next full write frame (addr 0x1, data 0xFF) strobes correctly.
- Over-clocking: 16 extra sclk cycles after a complete write frame (addr 0x2, data 0x3C) -> single strobe only; state DONE until cs_n rises.
- Async rst asserted mid-DATA of a read -> all outputs 0 within the reset cycle, no frame_err; post-reset write frame addr 0xF, data 0x01 succeeds.
- Back-to-back frames (write addr 0x3 data 0x77, then read addr 0x3 with rd_data_in = 0x77), cs_n high 3 clk between them -> one strobe, then one read returning 0x77 on MISO.
